// File: rtl/proj_qsys_pkg.sv
// Shared constants for the Qsys push-button controller: register word addresses
// and the default debounce length (10 ms at 50 MHz).
package proj_qsys_pkg;

   localparam logic [1:0] BTN_ADDR_DATA  = 2'd0;
   localparam logic [1:0] BTN_ADDR_MASK  = 2'd1;
   localparam logic [1:0] BTN_ADDR_EDGE  = 2'd2;
   localparam logic [1:0] BTN_ADDR_COUNT = 2'd3;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/button_debounce.sv
// One button lane: 2-flop synchroniser, stable-level debounce counter and a
// single-cycle press pulse on the accepted released->pressed transition.
module button_debounce
   import proj_qsys_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_btn_n,
   output logic o_stable,
   output logic o_press
);

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stable;
   logic             r_press;
   logic             w_sample;

   assign w_sample = ~r_sync[1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync   <= 2'b11;
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_press  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_btn_n};
         r_press <= 1'b0;
         if (w_sample == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= w_sample;
            r_cnt    <= '0;
            r_press  <= w_sample;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_press  = r_press;

endmodule

// File: rtl/proj_qsys_button_ctrl.sv
// Avalon-MM push-button controller: debounced levels, W1C press capture, maskable irq.
// Optional per-button press counters at address 3 when BUTTON_PRESS_COUNT_EN is defined.
module proj_qsys_button_ctrl
   import proj_qsys_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int N_CNT_RD = (WIDTH < 4) ? WIDTH : 4;

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_press;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edge;
   logic [31:0]      r_readdata;
   logic [31:0]      w_rdata;
   logic [31:0]      w_count_rd;
   logic             r_irq;
   logic             w_wr;
   logic             w_unused;

   for (genvar g = 0; g < WIDTH; g++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk      (clk),
         .reset_n  (reset_n),
         .i_btn_n  (in_port[g]),
         .o_stable (w_stable[g]),
         .o_press  (w_press[g])
      );
   end

   assign w_wr     = chipselect & ~write_n;
   assign w_clr    = (w_wr && address == BTN_ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
   assign w_unused = ^writedata[31:WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mask     <= '0;
         r_edge     <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (w_wr && address == BTN_ADDR_MASK) r_mask <= writedata[WIDTH-1:0];
         // A press arriving with a clear of the same bit keeps the bit set.
         r_edge     <= w_press | (r_edge & ~w_clr);
         r_irq      <= |(r_edge & r_mask);
         r_readdata <= w_rdata;
      end
   end

`ifdef BUTTON_PRESS_COUNT_EN
   logic [7:0] r_cnt [WIDTH];

   // NOTE: this small counter array is reset element by element; large RAM-style
   // arrays should stay unreset so they can map onto block memory.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else if (w_wr && address == BTN_ADDR_COUNT) begin
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++)
            if (w_press[i]) r_cnt[i] <= r_cnt[i] + 8'd1;
      end
   end

   always_comb begin
      w_count_rd = '0;
      for (int i = 0; i < N_CNT_RD; i++) w_count_rd[8*i +: 8] = r_cnt[i];
   end
`else
   assign w_count_rd = '0;
`endif

   // NOTE: w_rdata gets its default before the case so no path can infer a latch.
   always_comb begin
      w_rdata = '0;
      case (address)
         BTN_ADDR_DATA:  w_rdata[WIDTH-1:0] = w_stable;
         BTN_ADDR_MASK:  w_rdata[WIDTH-1:0] = r_mask;
         BTN_ADDR_EDGE:  w_rdata[WIDTH-1:0] = r_edge;
         BTN_ADDR_COUNT: w_rdata            = w_count_rd;
         default:        w_rdata            = '0;
      endcase
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule
